// File: rtl/serial_fsub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_fsub_if #(
  parameter int unsigned WIDTH = 2
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_fsub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Result and borrow-out are registered and hold until the next completion.
module serial_fsub #(
  parameter int unsigned WIDTH = 2
) (
  input logic         clk,
  input logic         rst_n,
  serial_fsub_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             d_bit;
  logic             brw_nxt;
  logic [WIDTH-1:0] d_msb;
  logic [WIDTH-1:0] acc_shift;

  // One full-subtractor slice on the current LSBs plus the accumulator shift.
  always_comb begin
    d_bit            = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    brw_nxt          = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
    d_msb            = '0;
    d_msb[WIDTH-1]   = d_bit;
    // Written as a shift-or so WIDTH=1 needs no zero-width slice.
    acc_shift        = (acc_q >> 1) | d_msb;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = brw_nxt;
        acc_d  = acc_shift;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          diff_d  = acc_shift;
          bout_d  = brw_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      brw_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_fsub.sv
// Bench for serial_fsub: WIDTH=2 and WIDTH=3 instances, a cycle-level reference
// model checked every negedge, plus directed vectors with literal expectations.
module tb_serial_fsub;

  logic clk;
  logic rst_n;

  serial_fsub_if #(.WIDTH(2)) bus2 ();
  serial_fsub_if #(.WIDTH(3)) bus3 ();

  serial_fsub #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  serial_fsub #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {bout,diff} as the (w+1)-bit two's-complement value of a - b - bin.
  function automatic logic [3:0] ref_sub(input int unsigned w, input logic [2:0] a,
                                         input logic [2:0] b, input logic bin);
    int v;
    v = int'(a) - int'(b) - int'(bin);
    return 4'(v) & 4'((1 << (w + 1)) - 1);
  endfunction

  // Reference model: countdown of remaining busy cycles and the pending result.
  int unsigned m2_left, m3_left;
  logic        m2_done, m3_done;
  logic [3:0]  m2_res, m3_res, m2_out, m3_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_left <= 0; m2_done <= 1'b0; m2_res <= '0; m2_out <= '0;
    end else if (m2_left != 0) begin
      m2_left <= m2_left - 1;
      m2_done <= (m2_left == 1);
      if (m2_left == 1) m2_out <= m2_res;
    end else begin
      m2_done <= 1'b0;
      if (bus2.start) begin
        m2_left <= 2;
        m2_res  <= ref_sub(2, {1'b0, bus2.a}, {1'b0, bus2.b}, bus2.bin);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3_left <= 0; m3_done <= 1'b0; m3_res <= '0; m3_out <= '0;
    end else if (m3_left != 0) begin
      m3_left <= m3_left - 1;
      m3_done <= (m3_left == 1);
      if (m3_left == 1) m3_out <= m3_res;
    end else begin
      m3_done <= 1'b0;
      if (bus3.start) begin
        m3_left <= 3;
        m3_res  <= ref_sub(3, bus3.a, bus3.b, bus3.bin);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("w2_done", 32'(bus2.done), 32'(m2_done));
    chk("w2_busy", 32'(bus2.busy), 32'(m2_left != 0));
    chk("w2_result", 32'({bus2.bout, bus2.diff}), 32'(m2_out[2:0]));
    chk("w3_done", 32'(bus3.done), 32'(m3_done));
    chk("w3_busy", 32'(bus3.busy), 32'(m3_left != 0));
    chk("w3_result", 32'({bus3.bout, bus3.diff}), 32'(m3_out));
  end

  task automatic drive(input int w, input logic st, input logic [2:0] a, input logic [2:0] b,
                       input logic bin);
    if (w == 2) begin
      bus2.start = st; bus2.a = a[1:0]; bus2.b = b[1:0]; bus2.bin = bin;
    end else begin
      bus3.start = st; bus3.a = a; bus3.b = b; bus3.bin = bin;
    end
  endtask

  // Runs one operation from an idle DUT; latency counts the accepting edge as edge 1.
  task automatic op(input int w, input logic [2:0] a, input logic [2:0] b, input logic bin,
                    input logic [2:0] exp_diff, input logic exp_bout, input string name);
    int   k;
    logic dn;
    drive(w, 1'b1, a, b, bin);
    k  = 0;
    dn = 1'b0;
    while (!dn && k < 12) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) drive(w, 1'b0, a, b, bin);
      dn = (w == 2) ? bus2.done : bus3.done;
    end
    chk({name, "_latency"}, 32'(k), 32'(w + 1));
    if (w == 2) begin
      chk({name, "_diff"}, 32'(bus2.diff), 32'(exp_diff[1:0]));
      chk({name, "_bout"}, 32'(bus2.bout), 32'(exp_bout));
    end else begin
      chk({name, "_diff"}, 32'(bus3.diff), 32'(exp_diff));
      chk({name, "_bout"}, 32'(bus3.bout), 32'(exp_bout));
    end
  endtask

  initial begin
    int   dones;
    logic [2:0] s;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive(2, 1'b0, 3'd0, 3'd0, 1'b0);
    drive(3, 1'b0, 3'd0, 3'd0, 1'b0);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus2.busy), 32'd0);
    chk("rst_done", 32'(bus2.done), 32'd0);
    chk("rst_diff", 32'(bus2.diff), 32'd0);
    chk("rst_bout", 32'(bus2.bout), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_outputs", 32'({bus2.busy, bus2.done, bus2.bout, bus2.diff}), 32'd0);

    // Pin the model with hand-computed values.
    chk("model_pin_a", 32'(ref_sub(2, 3'd0, 3'd0, 1'b1)), 32'b111);
    chk("model_pin_b", 32'(ref_sub(2, 3'd3, 3'd1, 1'b0)), 32'b010);
    chk("model_pin_c", 32'(ref_sub(3, 3'd5, 3'd2, 1'b1)), 32'b0010);

    // Basic directed cases.
    op(2, 3'b000, 3'b000, 1'b1, 3'b011, 1'b1, "basic0");
    op(2, 3'b011, 3'b001, 1'b0, 3'b010, 1'b0, "basic1");
    op(2, 3'b010, 3'b001, 1'b1, 3'b000, 1'b0, "basic2");
    op(2, 3'b011, 3'b011, 1'b1, 3'b011, 1'b1, "basic3");

    // Exhaustive WIDTH=2, back-to-back from the done cycle.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          s = 3'(a - b - c);
          op(2, 3'(a), 3'(b), 1'(c), {1'b0, s[1:0]}, s[2], "exh");
        end
      end
    end

    // Adder round-trip on the WIDTH=3 instance.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          s = 3'(a + b + c);
          op(3, s, 3'(b), 1'(c), 3'(a), 1'b0, "roundtrip");
        end
      end
    end
    @(posedge clk);
    #1;

    // start pulsed mid-operation with different operands is ignored.
    drive(2, 1'b1, 3'b011, 3'b001, 1'b0);
    @(posedge clk);
    #1;
    drive(2, 1'b1, 3'b000, 3'b011, 1'b1);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 3'b000, 3'b011, 1'b1);
    @(posedge clk);
    #1;
    chk("ignore_done", 32'(bus2.done), 32'd1);
    chk("ignore_diff", 32'(bus2.diff), 32'b10);
    chk("ignore_bout", 32'(bus2.bout), 32'd0);
    @(posedge clk);
    #1;

    // start held high: one result every 3 cycles, operands change every cycle.
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      drive(2, 1'b1, 3'(i * 3 + 1), 3'(i * 2 + 3), 1'(i));
      @(posedge clk);
      #1;
      if (bus2.done) dones++;
    end
    drive(2, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("held_done_count", 32'(dones), 32'd3);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-operation.
    drive(2, 1'b1, 3'b011, 3'b001, 1'b0);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 3'b011, 3'b001, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_outputs", 32'({bus2.busy, bus2.done, bus2.bout, bus2.diff}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus2.done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    op(2, 3'b011, 3'b001, 1'b0, 3'b010, 1'b0, "after_rst");
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule

// File: doc/serial_fsub.md
# serial_fsub

Bit-serial WIDTH-bit subtractor with borrow-in and borrow-out. It is the inverse-direction counterpart of the team's 2-bit ripple full adder. It computes Diff = A − B − Bin one bit per clock, LSB first, behind a start/busy/done handshake. It is used as an area-cheap arithmetic unit and as the checker that undoes adder results: {Cout,Sum} − B − Cin must return A.

## Interface
- WIDTH, default 2: operand and result width; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on an accepted start.
- B  input  WIDTH  subtrahend; captured on an accepted start.
- Bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Diff/Bout are updated.
- Diff  output  WIDTH  result, (A − B − Bin) mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).

## Operation
- States: IDLE, SHIFT. Internal regs: a_sh, b_sh (WIDTH), brw (1), acc (WIDTH), cnt (ceil(log2(WIDTH+1)) bits).
- IDLE with start=1 at an edge:
  - load a_sh=A, b_sh=B, brw=Bin, cnt=0, acc=0.
  - busy←1; go to SHIFT.
- SHIFT, each edge:
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - shift a_sh and b_sh right by 1; shift acc right by 1 with d entering the MSB; cnt←cnt+1.
- Completion, on the edge processing bit WIDTH−1 (cnt==WIDTH−1):
  - Diff←{d, acc[WIDTH−1:1]}; Bout←borrow out of the final bit.
  - done←1; busy←0; state←IDLE.
- done is otherwise 0. Diff and Bout hold their values until the next completion.
- start while busy: ignored. Inputs are not re-sampled and the operation is unaffected.
- A, B and Bin may change freely after the accepting edge.
- start high in the cycle done is high: the state is already IDLE, so the request is accepted. This gives back-to-back operation with no dead cycle.
- WIDTH=1: the operation completes on the first SHIFT edge.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, Diff=0, Bout=0, all internal regs 0.
  - The in-flight operation is discarded.
  - The first edge after release samples start normally.

## Timing
- Edge E0 accepts start; busy is high from after E0.
- Edges E1..E_WIDTH process bits 0..WIDTH−1.
- After E_WIDTH: done=1 for exactly one cycle, busy=0, Diff/Bout valid.
- Latency from accepting edge to done high: WIDTH+1 edges (3 for WIDTH=2). busy is high for exactly WIDTH cycles.
- Throughput: one result per WIDTH+1 cycles with start held high.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset values: assert rst_n=0 → busy=0, done=0, Diff=00, Bout=0. Release, start=0 for 5 cycles → all outputs unchanged.
- Basic cases, WIDTH=2:
  - A=00, B=00, Bin=1 → Diff=11, Bout=1.
  - A=11, B=01, Bin=0 → Diff=10, Bout=0.
  - A=10, B=01, Bin=1 → Diff=00, Bout=0.
  - A=11, B=11, Bin=1 → Diff=11, Bout=1.
  - Each case: done exactly 3 edges after the accepting edge.
- Exhaustive, WIDTH=2: all 32 combinations of {A,B,Bin}. {Bout,Diff} must equal the 3-bit two's-complement value of A−B−Bin.
- Adder round-trip: for all A, B, Cin, let {Cout,Sum} = A+B+Cin, and run a WIDTH=3 instance on ({Cout,Sum}, {0,B}, Cin). Required result: Diff={0,A}, Bout=0.
- Handshake:
  - start pulsed mid-operation with different operands → ignored; the original result is produced.
  - start held high continuously → done pulses every 3 cycles, with results matching the operands sampled at each accepting edge.
- Reset mid-op: start A=11, B=01, then assert rst_n after E1 → no done pulse; Diff=00, Bout=0. The next operation after release completes correctly.
